// File: rtl/wdog_reset_ctrl.sv
// Reset sequencer: POR hold, staged wdogresn/sys_resetn release, watchdog and software resets.
// Build option: define WDOG_RESET_CTRL_SW_REQ_EN to honour sw_reset_req (FULL_HOLD path).
module wdog_reset_ctrl #(
    parameter int HOLD_CYCLES = 16,
    parameter int WDOG_DELAY  = 4
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       wdogres,
    input  logic       sw_reset_req,
    output logic       sys_resetn,
    output logic       wdogresn,
    output logic [1:0] reset_cause,
    output logic       busy
);

    typedef enum logic [2:0] {
        POR_HOLD  = 3'd0,
        WDOG_REL  = 3'd1,
        RUN       = 3'd2,
        SYS_HOLD  = 3'd3,
        FULL_HOLD = 3'd4
    } state_t;

    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] WREL_LAST  = 8'(WDOG_DELAY - 1);
    localparam logic [1:0] CAUSE_POR  = 2'b01;
    localparam logic [1:0] CAUSE_WDOG = 2'b10;
    localparam logic [1:0] CAUSE_SW   = 2'b11;

    logic [1:0] por_sync_q, por_sync_d;
    logic [2:0] wd_sync_q, wd_sync_d;
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       sys_resetn_q, sys_resetn_d;
    logic       wdogresn_q, wdogresn_d;
    logic [1:0] cause_q, cause_d;
    logic       por_rel, wd_rise, sw_req, hold_done, wrel_done;

`ifdef WDOG_RESET_CTRL_SW_REQ_EN
    assign sw_req = sw_reset_req;
`else
    logic unused_sw_reset_req;
    assign unused_sw_reset_req = sw_reset_req;
    assign sw_req = 1'b0;
`endif

    // Synchronisers: por chain shifts in 1s so release lands on the 2nd edge;
    // third wdogres stage only exists to detect a synchronised 0->1.
    assign por_sync_d = {por_sync_q[0], 1'b1};
    assign wd_sync_d  = {wd_sync_q[1:0], wdogres};
    assign por_rel    = por_sync_q[1];
    assign wd_rise    = wd_sync_q[1] & ~wd_sync_q[2];
    assign hold_done  = (cnt_q == HOLD_LAST);
    assign wrel_done  = (cnt_q == WREL_LAST);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            por_sync_q   <= 2'b00;
            wd_sync_q    <= 3'b000;
            state_q      <= POR_HOLD;
            cnt_q        <= 8'd0;
            sys_resetn_q <= 1'b0;
            wdogresn_q   <= 1'b0;
            cause_q      <= CAUSE_POR;
        end else begin
            por_sync_q   <= por_sync_d;
            wd_sync_q    <= wd_sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sys_resetn_q <= sys_resetn_d;
            wdogresn_q   <= wdogresn_d;
            cause_q      <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            POR_HOLD:  if (por_rel && hold_done) state_d = WDOG_REL;
            WDOG_REL:  if (wrel_done) state_d = RUN;
            RUN: begin
                if (sw_req)       state_d = FULL_HOLD;
                else if (wd_rise) state_d = SYS_HOLD;
            end
            SYS_HOLD:  if (hold_done) state_d = RUN;
            FULL_HOLD: if (hold_done) state_d = WDOG_REL;
            default:   state_d = POR_HOLD;
        endcase
    end

    // Reset outputs are registered from the next state so they change on the entry edge.
    always_comb begin
        sys_resetn_d = (state_d == RUN);
        wdogresn_d   = (state_d == WDOG_REL) || (state_d == RUN) || (state_d == SYS_HOLD);
        cause_d      = cause_q;
        if (state_q == RUN && state_d == SYS_HOLD)  cause_d = CAUSE_WDOG;
        if (state_q == RUN && state_d == FULL_HOLD) cause_d = CAUSE_SW;
        if (state_d != state_q)
            cnt_d = 8'd0;
        else if (state_q == RUN || (state_q == POR_HOLD && !por_rel))
            cnt_d = 8'd0;
        else
            cnt_d = cnt_q + 8'd1;
    end

    assign sys_resetn  = sys_resetn_q;
    assign wdogresn    = wdogresn_q;
    assign reset_cause = cause_q;
    assign busy        = (state_q != RUN);

endmodule

// File: tb/tb_wdog_reset_ctrl.sv
// Scoreboard bench for wdog_reset_ctrl: timeline reference model pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_wdog_reset_ctrl;
    localparam int HOLD  = 16;
    localparam int WDLY  = 4;
    localparam int NEVER = 1000000000;
`ifdef WDOG_RESET_CTRL_SW_REQ_EN
    localparam bit SW_EN = 1'b1;
`else
    localparam bit SW_EN = 1'b0;
`endif

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic       wdogres = 1'b0;
    logic       sw_reset_req = 1'b0;
    logic       sys_resetn, wdogresn, busy;
    logic [1:0] reset_cause;

    wdog_reset_ctrl #(.HOLD_CYCLES(HOLD), .WDOG_DELAY(WDLY)) dut (
        .pclk(pclk), .presetn(presetn), .wdogres(wdogres), .sw_reset_req(sw_reset_req),
        .sys_resetn(sys_resetn), .wdogresn(wdogresn), .reset_cause(reset_cause), .busy(busy)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic       sysn;
        logic       wdn;
        logic [1:0] cause;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   k = 0;

    // Reference model: each reset output is high from a known edge index onward.
    int         wd_up, sys_up;
    logic [1:0] m_cause;
    bit         por_wait;
    logic       h1, h2, h3;

    task automatic model_por();
        wd_up = NEVER; sys_up = NEVER; m_cause = 2'b01; por_wait = 1'b1;
        h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    endtask

    task automatic model_edge(input logic rn_s, input logic wr_s, input logic sw_s);
        bit run_pre, rise;
        if (!rn_s) begin
            model_por();
        end else begin
            if (por_wait) begin
                wd_up    = k + HOLD + 1;
                sys_up   = k + HOLD + WDLY + 1;
                por_wait = 1'b0;
            end
            run_pre = (k - 1 >= sys_up);
            rise    = h2 && !h3;
            h3 = h2; h2 = h1; h1 = wr_s;
            if (run_pre) begin
                if (SW_EN && sw_s) begin
                    wd_up = k + HOLD; sys_up = k + HOLD + WDLY; m_cause = 2'b11;
                end else if (rise) begin
                    sys_up = k + HOLD; m_cause = 2'b10;
                end
            end
        end
    endtask

    task automatic step(input logic rn, input logic wr, input logic sw);
        exp_t e;
        @(posedge pclk);
        k++;
        model_edge(presetn, wdogres, sw_reset_req);
        #1;
        presetn = rn; wdogres = wr; sw_reset_req = sw;
        if (!rn) model_por();
        e.sysn  = (k >= sys_up);
        e.wdn   = (k >= wd_up);
        e.cause = m_cause;
        e.busy  = !(k >= sys_up);
        exp_q.push_back(e);
    endtask

    task automatic run(input int n, input logic rn, input logic wr, input logic sw);
        for (int i = 0; i < n; i++) step(rn, wr, sw);
    endtask

    always @(negedge pclk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            vectors++;
            if ({sys_resetn, wdogresn, reset_cause, busy} !== mon_e) begin
                miscompares++;
                $display("FAIL outputs @edge %0d: got sysn=%b wdogn=%b cause=%b busy=%b, want sysn=%b wdogn=%b cause=%b busy=%b",
                         k, sys_resetn, wdogresn, reset_cause, busy,
                         mon_e.sysn, mon_e.wdn, mon_e.cause, mon_e.busy);
            end
        end
    end

    int   rst_left = 0;
    logic r_rn, r_wr, r_sw;

    initial begin
        model_por();
        // power-on hold and release sequence
        run(3, 1'b0, 1'b0, 1'b0);
        run(30, 1'b1, 1'b0, 1'b0);
        // watchdog level held 50 cycles: exactly one SYS_HOLD
        run(50, 1'b1, 1'b1, 1'b0);
        run(20, 1'b1, 1'b0, 1'b0);
        // software pulse
        step(1'b1, 1'b0, 1'b1);
        run(30, 1'b1, 1'b0, 1'b0);
        // software request on the same edge the synchronised wdogres rise acts
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        run(40, 1'b1, 1'b0, 1'b0);
        // presetn pulse during SYS_HOLD cycle 7, then full POR sequence again
        step(1'b1, 1'b1, 1'b0);
        run(2, 1'b1, 1'b1, 1'b0);
        run(7, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        run(40, 1'b1, 1'b0, 1'b0);
        // randomized traffic including rare power-on resets
        r_wr = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (rst_left > 0) begin
                rst_left--; r_rn = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                rst_left = $urandom_range(0, 2); r_rn = 1'b0;
            end else begin
                r_rn = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) r_wr = ~r_wr;
            r_sw = ($urandom_range(0, 24) == 0);
            step(r_rn, r_wr, r_sw);
        end
        run(30, 1'b1, 1'b0, 1'b0);
        @(negedge pclk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
